ac_ph_packetizer: RTL and testbench

- Sits directly downstream of the computing cascade and consumes its per-channel result stream (o_vld, address_output, ac, ph).
- Collects one amplitude/phase pair per channel into a register bank.
- When every channel has been refreshed, snapshots the bank and serializes it as a byte packet over a valid/ready stream toward the host link (UART/USB bridge).
- Upstream has no backpressure, so the block never stalls its input.

---
 rtl/ac_ph_packetizer.sv | 139 +++++++++++++
 tb/tb_ac_ph_packetizer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_ph_packetizer.sv
// Collects one amplitude/phase pair per channel from the cascade. Once every channel
// has been refreshed, it snapshots the bank and streams it out as a checksummed byte packet.
module ac_ph_packetizer #(
  parameter int          CHANELS = 4,
  parameter int          DATA_W  = 32,
  parameter logic [7:0]  HEADER  = 8'hA5,
  localparam int         AW      = $clog2(CHANELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [AW-1:0]     i_addres,
  input  logic [DATA_W-1:0] i_ac,
  input  logic [DATA_W-1:0] i_ph,
  output logic [7:0]        o_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              o_last,
  output logic              overrun,
  output logic              busy
);

  localparam int NB = DATA_W / 8;
  localparam int EB = 2 * NB;
  localparam int BW = $clog2(EB);

  typedef logic [EB-1:0][7:0] entry_t;
  typedef enum logic [2:0] {IDLE, HDR, SEQ, PAY, CSUM} state_t;

  state_t                   state_q, state_d;
  entry_t [CHANELS-1:0]     bank_q, bank_d, shadow_q, shadow_d;
  logic   [CHANELS-1:0]     mask_q, mask_d;
  logic   [AW-1:0]          ch_q, ch_d;
  logic   [BW-1:0]          byte_q, byte_d;
  logic   [7:0]             seq_q, seq_d, csum_q, csum_d;
  logic                     overrun_q, overrun_d;
  logic                     snap, wr_ok;
  logic   [7:0]             pay_byte;

  assign snap     = (state_q == IDLE) && (&mask_q);
  assign wr_ok    = i_vld && (int'(i_addres) < CHANELS);
  // Entries are stored {ac, ph}; byte EB-1 is the ac MSB, sent first.
  assign pay_byte = shadow_q[ch_q][BW'(EB-1) - byte_q];
  assign o_valid  = (state_q != IDLE);
  assign busy     = (state_q != IDLE);
  assign overrun  = overrun_q;

  // Capture path never stalls. A write on the snapshot edge lands after the mask clear.
  always_comb begin
    bank_d    = bank_q;
    mask_d    = snap ? '0 : mask_q;
    overrun_d = 1'b0;
    if (wr_ok) begin
      bank_d[i_addres] = {i_ac, i_ph};
      mask_d[i_addres] = 1'b1;
      if (mask_q[i_addres] && !snap) overrun_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    ch_d     = ch_q;
    byte_d   = byte_q;
    seq_d    = seq_q;
    csum_d   = csum_q;
    o_data   = 8'h00;
    o_last   = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap) begin
          shadow_d = bank_q;
          csum_d   = 8'h00;
          ch_d     = '0;
          byte_d   = '0;
          state_d  = HDR;
        end
      end
      HDR: begin
        o_data = HEADER;
        if (o_ready) state_d = SEQ;
      end
      SEQ: begin
        o_data = seq_q;
        if (o_ready) begin
          csum_d  = csum_q ^ seq_q;
          state_d = PAY;
        end
      end
      PAY: begin
        o_data = pay_byte;
        if (o_ready) begin
          csum_d = csum_q ^ pay_byte;
          if (byte_q == BW'(EB-1)) begin
            byte_d = '0;
            if (ch_q == AW'(CHANELS-1)) state_d = CSUM;
            else                        ch_d    = ch_q + 1'b1;
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      CSUM: begin
        o_data = csum_q;
        o_last = 1'b1;
        if (o_ready) begin
          seq_d   = seq_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bank_q    <= '0;
      shadow_q  <= '0;
      mask_q    <= '0;
      ch_q      <= '0;
      byte_q    <= '0;
      seq_q     <= 8'h00;
      csum_q    <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      shadow_q  <= shadow_d;
      mask_q    <= mask_d;
      ch_q      <= ch_d;
      byte_q    <= byte_d;
      seq_q     <= seq_d;
      csum_q    <= csum_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_ac_ph_packetizer.sv
// Directed bench for ac_ph_packetizer: packet content, handshake stalls, overrun,
// snapshot-while-busy and mid-packet reset.
module tb_ac_ph_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_vld;
  logic [1:0]  i_addres;
  logic [31:0] i_ac, i_ph;
  logic [7:0]  o_data;
  logic        o_valid, o_ready, o_last, overrun, busy;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  int ov_base;

  logic [31:0] va [4];
  logic [31:0] vp [4];
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  t2_q[$];

  ac_ph_packetizer dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_addres(i_addres), .i_ac(i_ac), .i_ph(i_ph),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overrun === 1'b1) ov_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [31:0] ac, input logic [31:0] ph);
    i_vld    = 1'b1;
    i_addres = 2'(ch);
    i_ac     = ac;
    i_ph     = ph;
    tick();
    i_vld    = 1'b0;
  endtask

  task automatic write_set();
    for (int c = 0; c < 4; c++) wr(c, va[c], vp[c]);
  endtask

  // Expected packet: header, seq, per channel ac then ph MSB first, XOR of seq+payload.
  task automatic build(input logic [7:0] s);
    logic [7:0] cs;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(s);
    cs = s;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 2; w++)
        for (int k = 3; k >= 0; k--) begin
          b = (w == 0) ? va[c][8*k +: 8] : vp[c][8*k +: 8];
          exp_q.push_back(b);
          cs = cs ^ b;
        end
    exp_q.push_back(cs);
  endtask

  task automatic cmp_pkt(input string tag);
    int bad = 0;
    chk({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) bad++;
    chk({tag, "_bytes"}, 64'(bad), 64'd0);
  endtask

  // Starts #1 after an edge with the packet already offered; returns #1 after the last accept.
  task automatic collect(input string tag, input int pct);
    logic [7:0] held_d;
    logic       held_l;
    logic       held_v = 1'b0;
    logic       done   = 1'b0;
    int         stall_bad = 0;
    int         last_bad  = 0;
    got.delete();
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      o_ready = ($urandom_range(0, 99) < pct);
      if (held_v && (o_valid !== 1'b1 || o_data !== held_d || o_last !== held_l)) stall_bad++;
      held_v = 1'b0;
      if (o_valid && o_ready) begin
        got.push_back(o_data);
        if (o_last !== (got.size() == 35)) last_bad++;
        if (o_last) done = 1'b1;
      end else if (o_valid) begin
        held_v = 1'b1;
        held_d = o_data;
        held_l = o_last;
      end
      tick();
    end
    o_ready = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_stall"}, 64'(stall_bad), 64'd0);
    chk({tag, "_last"}, 64'(last_bad), 64'd0);
  endtask

  initial begin
    rst = 1'b1; i_vld = 1'b0; i_addres = 2'd0; i_ac = '0; i_ph = '0; o_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // All-zero set: o_valid rises two edges after the ch3 strobe is sampled.
    for (int c = 0; c < 4; c++) begin va[c] = '0; vp[c] = '0; end
    write_set();
    chk("t1_lat_idle", 64'(o_valid), 64'd0);
    tick();
    chk("t1_lat_valid", 64'(o_valid), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_hdr", 64'(o_data), 64'hA5);
    collect("t1", 100);
    build(8'h00);
    cmp_pkt("t1");
    chk("t1_seq", 64'(got[1]), 64'h00);
    chk("t1_csum", 64'(got[34]), 64'h00);
    chk("t1_idle", 64'(o_valid), 64'd0);

    // Fresh reset so seq=0: checksum is 01^FF^FF^FF^80 = 7E.
    rst = 1'b1; tick(); rst = 1'b0;
    va[0] = 32'h0000_0001; vp[1] = 32'hFFFF_FF80;
    write_set();
    tick();
    collect("t2", 100);
    build(8'h00);
    cmp_pkt("t2");
    chk("t2_ac0", 64'(got[5]), 64'h01);
    chk("t2_ph1_msb", 64'(got[14]), 64'hFF);
    chk("t2_ph1_lsb", 64'(got[17]), 64'h80);
    chk("t2_csum", 64'(got[34]), 64'h7E);
    t2_q = got;

    // Same data, 30% ready: identical bytes except seq=01 and checksum 7E^01=7F.
    write_set();
    tick();
    collect("t3", 30);
    begin
      int bad = 0;
      for (int i = 0; i < 35; i++)
        if (i != 1 && i != 34 && got[i] !== t2_q[i]) bad++;
      chk("t3_same", 64'(bad), 64'd0);
    end
    chk("t3_len", 64'(got.size()), 64'd35);
    chk("t3_seq", 64'(got[1]), 64'h01);
    chk("t3_csum", 64'(got[34]), 64'h7F);

    // ch2 rewritten before the set completes: one overrun, newest value wins.
    ov_base = ov_cnt;
    for (int c = 0; c < 4; c++) begin va[c] = '0; vp[c] = '0; end
    wr(2, 32'd5, 32'd0);
    wr(0, 32'd0, 32'd0);
    wr(1, 32'd0, 32'd0);
    chk("t4_no_ov", 64'(overrun), 64'd0);
    wr(2, 32'd9, 32'd0);
    chk("t4_ov_pulse", 64'(overrun), 64'd1);
    wr(3, 32'd0, 32'd0);
    chk("t4_ov_drop", 64'(overrun), 64'd0);
    tick();
    collect("t4", 100);
    va[2] = 32'd9;
    build(8'h02);
    cmp_pkt("t4");
    chk("t4_ac2", 64'(got[21]), 64'h09);
    chk("t4_ov_cnt", 64'(ov_cnt - ov_base), 64'd1);

    // Set A starts a packet; set B arrives while it stalls; ch1 written on the snapshot edge.
    ov_base = ov_cnt;
    for (int c = 0; c < 4; c++) begin va[c] = 32'hA000_0000 + c; vp[c] = 32'h0000_B000 + c; end
    write_set();
    tick();
    chk("t5_p1_busy", 64'(busy), 64'd1);
    for (int c = 0; c < 4; c++) wr(c, 32'h1111_1111 * (c + 1), ~(32'h1111_1111 * (c + 1)));
    chk("t5_p1_held", 64'(o_data), 64'hA5);
    collect("t5p1", 100);
    build(8'h03);
    cmp_pkt("t5p1");
    chk("t5_gap_idle", 64'(o_valid), 64'd0);
    wr(1, 32'hC1C2_C3C4, 32'h0);
    chk("t5_p2_valid", 64'(o_valid), 64'd1);
    collect("t5p2", 100);
    for (int c = 0; c < 4; c++) begin va[c] = 32'h1111_1111 * (c + 1); vp[c] = ~va[c]; end
    build(8'h04);
    cmp_pkt("t5p2");
    chk("t5_mask", 64'(dut.mask_q), 64'b0010);
    chk("t5_ov_cnt", 64'(ov_cnt - ov_base), 64'd0);

    // ch1 already pending, so ch0/2/3 complete the set; reset after 10 bytes.
    for (int c = 0; c < 4; c++) begin va[c] = 32'h5500_0000 + c; vp[c] = 32'h0066_0000 + c; end
    wr(0, va[0], vp[0]);
    wr(2, va[2], vp[2]);
    wr(3, va[3], vp[3]);
    tick();
    va[1] = 32'hC1C2_C3C4; vp[1] = 32'h0;
    build(8'h05);
    got.delete();
    begin
      int last_seen = 0;
      o_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
        got.push_back(o_data);
        if (o_last === 1'b1) last_seen++;
        tick();
      end
      o_ready = 1'b0;
      chk("t6_no_last", 64'(last_seen), 64'd0);
    end
    begin
      int bad = 0;
      for (int i = 0; i < 10; i++) if (got[i] !== exp_q[i]) bad++;
      chk("t6_prefix", 64'(bad), 64'd0);
    end
    chk("t6_byte10", 64'(o_data), 64'hC1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_valid", 64'(o_valid), 64'd0);
    chk("t6_rst_last", 64'(o_last), 64'd0);
    chk("t6_rst_data", 64'(o_data), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    for (int c = 0; c < 4; c++) begin va[c] = 32'h0102_0304 << c; vp[c] = 32'h8000_0000 >> c; end
    write_set();
    tick();
    collect("t6", 100);
    build(8'h00);
    cmp_pkt("t6");
    chk("t6_seq", 64'(got[1]), 64'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
